fust_n: RTL and testbench

- Parametrised functional-unit status table (scoreboard) with one entry per functional unit.
- Each entry holds the dispatched op's register fields, source-producer tags, a speculation bit and a per-entry state machine (IDLE/WAIT/READY/EXEC).
- Tags clear in place on writeback broadcast, so operand readiness is tracked inside the table.
- Sits between dispatch and FU issue. Flush removes only speculative entries; branch resolve clears the spec bits.

---
 rtl/fust_n.sv | 135 +++++++++++++
 tb/tb_fust_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fust_n.sv
// Functional-unit status table: one entry per FU tracking the dispatched op,
// its producer tags, speculation bit and IDLE/WAIT/READY/EXEC lifecycle.
module fust_n #(
  parameter int NUM_FU = 3,
  parameter int REG_W  = 5,
  parameter int TAG_W  = $clog2(NUM_FU + 1)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         disp_en,
  input  logic [$clog2(NUM_FU)-1:0]    disp_fu,
  input  logic [REG_W-1:0]             disp_rd,
  input  logic [REG_W-1:0]             disp_rs1,
  input  logic [REG_W-1:0]             disp_rs2,
  input  logic [TAG_W-1:0]             disp_t1,
  input  logic [TAG_W-1:0]             disp_t2,
  input  logic                         disp_spec,
  output logic [NUM_FU-1:0]            disp_ready,
  output logic [NUM_FU-1:0]            issue_ready,
  input  logic [NUM_FU-1:0]            issue_en,
  input  logic [NUM_FU-1:0]            done_en,
  input  logic                         wb_en,
  input  logic [$clog2(NUM_FU)-1:0]    wb_fu,
  input  logic                         flush,
  input  logic                         resolved,
  output logic [NUM_FU-1:0]            busy,
  output logic [NUM_FU*REG_W-1:0]      ent_rd,
  output logic [NUM_FU*REG_W-1:0]      ent_rs1,
  output logic [NUM_FU*REG_W-1:0]      ent_rs2,
  output logic [NUM_FU*TAG_W-1:0]      ent_t1,
  output logic [NUM_FU*TAG_W-1:0]      ent_t2,
  output logic [NUM_FU-1:0]            ent_spec,
  output logic [$clog2(NUM_FU+1)-1:0]  num_busy
);

  localparam int CNT_W = $clog2(NUM_FU + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY, ST_EXEC} state_t;

  typedef struct packed {
    state_t               state;
    logic                 spec;
    logic [TAG_W-1:0]     t1;
    logic [TAG_W-1:0]     t2;
    logic [REG_W-1:0]     rd;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
  } ent_t;

  // Broadcast tag is wb_fu+1, held wide so wb_fu = NUM_FU-1.. cannot wrap.
  logic [31:0]       wb_tag;
  logic [NUM_FU-1:0] busy_next;
  logic [CNT_W-1:0]  num_busy_reg, num_busy_next;

  assign wb_tag = 32'(wb_fu) + 32'd1;

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_ent
      ent_t             ent_reg, ent_next;
      logic             t1_hit, t2_hit, dt1_hit, dt2_hit, disp_hit;
      logic [TAG_W-1:0] t1_woke, t2_woke, dt1, dt2;

      assign t1_hit   = wb_en && (32'(ent_reg.t1) == wb_tag);
      assign t2_hit   = wb_en && (32'(ent_reg.t2) == wb_tag);
      assign dt1_hit  = wb_en && (32'(disp_t1) == wb_tag);
      assign dt2_hit  = wb_en && (32'(disp_t2) == wb_tag);
      assign t1_woke  = t1_hit ? '0 : ent_reg.t1;
      assign t2_woke  = t2_hit ? '0 : ent_reg.t2;
      assign dt1      = dt1_hit ? '0 : disp_t1;
      assign dt2      = dt2_hit ? '0 : disp_t2;
      // A speculative op dispatched under flush is squashed before it lands.
      assign disp_hit = disp_en && (32'(disp_fu) == 32'(gi)) && !(flush && disp_spec);

      always_comb begin
        ent_next    = ent_reg;
        ent_next.t1 = t1_woke;
        ent_next.t2 = t2_woke;
        case (ent_reg.state)
          ST_IDLE: begin
            if (disp_hit) begin
              ent_next.rd    = disp_rd;
              ent_next.rs1   = disp_rs1;
              ent_next.rs2   = disp_rs2;
              ent_next.t1    = dt1;
              ent_next.t2    = dt2;
              ent_next.spec  = disp_spec;
              ent_next.state = (dt1 == '0 && dt2 == '0) ? ST_READY : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (t1_woke == '0 && t2_woke == '0) ent_next.state = ST_READY;
          end
          ST_READY: begin
            if (issue_en[gi]) ent_next.state = ST_EXEC;
          end
          ST_EXEC: begin
            if (done_en[gi]) ent_next = '0;
          end
          default: ent_next = '0;
        endcase
        if (flush && ent_reg.spec) ent_next = '0;
        if (resolved) ent_next.spec = 1'b0;
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ent_reg <= '0;
        else       ent_reg <= ent_next;
      end

      assign busy_next[gi]                  = (ent_next.state != ST_IDLE);
      assign busy[gi]                       = (ent_reg.state != ST_IDLE);
      assign disp_ready[gi]                 = (ent_reg.state == ST_IDLE);
      assign issue_ready[gi]                = (ent_reg.state == ST_READY);
      assign ent_spec[gi]                   = ent_reg.spec;
      assign ent_rd[gi*REG_W +: REG_W]      = ent_reg.rd;
      assign ent_rs1[gi*REG_W +: REG_W]     = ent_reg.rs1;
      assign ent_rs2[gi*REG_W +: REG_W]     = ent_reg.rs2;
      assign ent_t1[gi*TAG_W +: TAG_W]      = ent_reg.t1;
      assign ent_t2[gi*TAG_W +: TAG_W]      = ent_reg.t2;
    end
  endgenerate

  always_comb begin
    num_busy_next = '0;
    for (int i = 0; i < NUM_FU; i++) num_busy_next = num_busy_next + CNT_W'(busy_next[i]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) num_busy_reg <= '0;
    else       num_busy_reg <= num_busy_next;
  end

  assign num_busy = num_busy_reg;

endmodule

// File: tb/tb_fust_n.sv
// Bench for fust_n: directed vector table, hand-written reset sequence and
// randomized traffic checked against an occupancy-level reference model.
module tb_fust_n;
  localparam int N  = 3;
  localparam int RW = 5;
  localparam int TW = 2;
  localparam int FW = 2;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            disp_en;
  logic [FW-1:0]   disp_fu;
  logic [RW-1:0]   disp_rd, disp_rs1, disp_rs2;
  logic [TW-1:0]   disp_t1, disp_t2;
  logic            disp_spec;
  logic [N-1:0]    disp_ready, issue_ready, issue_en, done_en, busy, ent_spec;
  logic            wb_en;
  logic [FW-1:0]   wb_fu;
  logic            flush, resolved;
  logic [N*RW-1:0] ent_rd, ent_rs1, ent_rs2;
  logic [N*TW-1:0] ent_t1, ent_t2;
  logic [1:0]      num_busy;

  always #5 CLK = ~CLK;

  fust_n #(.NUM_FU(N), .REG_W(RW)) dut (
    .CLK(CLK), .nRST(nRST),
    .disp_en(disp_en), .disp_fu(disp_fu), .disp_rd(disp_rd), .disp_rs1(disp_rs1),
    .disp_rs2(disp_rs2), .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_spec(disp_spec),
    .disp_ready(disp_ready), .issue_ready(issue_ready), .issue_en(issue_en),
    .done_en(done_en), .wb_en(wb_en), .wb_fu(wb_fu), .flush(flush), .resolved(resolved),
    .busy(busy), .ent_rd(ent_rd), .ent_rs1(ent_rs1), .ent_rs2(ent_rs2),
    .ent_t1(ent_t1), .ent_t2(ent_t2), .ent_spec(ent_spec), .num_busy(num_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: an entry is either empty or holds an op that has or has not issued.
  bit m_v[N], m_iss[N], m_sp[N];
  int m_rd[N], m_rs1[N], m_rs2[N], m_t1[N], m_t2[N];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic m_clear(int i);
    m_v[i] = 0; m_iss[i] = 0; m_sp[i] = 0;
    m_rd[i] = 0; m_rs1[i] = 0; m_rs2[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_clear(i);
  endtask

  function automatic bit wb_hit(int t);
    return wb_en && (t == int'(wb_fu) + 1);
  endfunction

  task automatic m_clock();
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        bit rdy;
        rdy = !m_iss[i] && m_t1[i] == 0 && m_t2[i] == 0;
        if (flush && m_sp[i])            m_clear(i);
        else if (m_iss[i] && done_en[i]) m_clear(i);
        else begin
          if (rdy && issue_en[i]) m_iss[i] = 1;
          if (wb_hit(m_t1[i])) m_t1[i] = 0;
          if (wb_hit(m_t2[i])) m_t2[i] = 0;
        end
      end else if (disp_en && int'(disp_fu) == i && !(flush && disp_spec)) begin
        m_v[i]   = 1;
        m_iss[i] = 0;
        m_sp[i]  = disp_spec;
        m_rd[i]  = int'(disp_rd);
        m_rs1[i] = int'(disp_rs1);
        m_rs2[i] = int'(disp_rs2);
        m_t1[i]  = wb_hit(int'(disp_t1)) ? 0 : int'(disp_t1);
        m_t2[i]  = wb_hit(int'(disp_t2)) ? 0 : int'(disp_t2);
      end
      if (resolved) m_sp[i] = 0;
    end
  endtask

  task automatic check_model(string tag);
    logic [N-1:0]    eb, er, ed, es;
    logic [N*RW-1:0] erd, ers1, ers2;
    logic [N*TW-1:0] et1, et2;
    int nb;
    nb = 0;
    for (int i = 0; i < N; i++) begin
      eb[i] = m_v[i];
      er[i] = m_v[i] && !m_iss[i] && m_t1[i] == 0 && m_t2[i] == 0;
      ed[i] = !m_v[i];
      es[i] = m_sp[i];
      erd[i*RW +: RW]  = RW'(m_rd[i]);
      ers1[i*RW +: RW] = RW'(m_rs1[i]);
      ers2[i*RW +: RW] = RW'(m_rs2[i]);
      et1[i*TW +: TW]  = TW'(m_t1[i]);
      et2[i*TW +: TW]  = TW'(m_t2[i]);
      nb += int'(m_v[i]);
    end
    chk({tag, ".busy"},        64'(busy),        64'(eb));
    chk({tag, ".issue_ready"}, 64'(issue_ready), 64'(er));
    chk({tag, ".disp_ready"},  64'(disp_ready),  64'(ed));
    chk({tag, ".spec"},        64'(ent_spec),    64'(es));
    chk({tag, ".num_busy"},    64'(num_busy),    64'(nb));
    chk({tag, ".rd"},          64'(ent_rd),      64'(erd));
    chk({tag, ".rs1"},         64'(ent_rs1),     64'(ers1));
    chk({tag, ".rs2"},         64'(ent_rs2),     64'(ers2));
    chk({tag, ".t1"},          64'(ent_t1),      64'(et1));
    chk({tag, ".t2"},          64'(ent_t2),      64'(et2));
  endtask

  task automatic idle_inputs();
    disp_en = 0; disp_fu = '0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0;
    disp_t1 = '0; disp_t2 = '0; disp_spec = 0; issue_en = '0; done_en = '0;
    wb_en = 0; wb_fu = '0; flush = 0; resolved = 0;
  endtask

  // Inputs change only at #1 after a rising edge, so the model sees the same values as the DUT.
  task automatic step();
    @(posedge CLK);
    m_clock();
    #1;
  endtask

  typedef struct {
    logic de; logic [FW-1:0] fu; logic [RW-1:0] rd; logic [TW-1:0] t1, t2; logic sp;
    logic [N-1:0] iss, done; logic we; logic [FW-1:0] wf; logic fl, rs;
    logic [N-1:0] e_busy, e_ir, e_spec; logic [1:0] e_nb; logic [N*TW-1:0] e_t1;
    logic [N*RW-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(int de, int fu, int rd, int t1, int t2, int sp,
                              int iss, int done, int we, int wf, int fl, int rs,
                              int eb, int eir, int esp, int enb, int et1, int erd);
    vec_t v;
    v.de = 1'(de); v.fu = FW'(fu); v.rd = RW'(rd); v.t1 = TW'(t1); v.t2 = TW'(t2);
    v.sp = 1'(sp); v.iss = N'(iss); v.done = N'(done); v.we = 1'(we); v.wf = FW'(wf);
    v.fl = 1'(fl); v.rs = 1'(rs); v.e_busy = N'(eb); v.e_ir = N'(eir); v.e_spec = N'(esp);
    v.e_nb = 2'(enb); v.e_t1 = (N*TW)'(et1); v.e_rd = (N*RW)'(erd);
    return v;
  endfunction

  vec_t vecs[31];

  initial begin
    //            de fu rd t1 t2 sp iss dn we wf fl rs   busy ir spec nb t1     rd
    vecs[0]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,    2, 2, 0, 1, 0,     'h00E0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0,    2, 0, 0, 1, 0,     'h00E0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0,    0, 0, 0, 0, 0,     'h0000);
    vecs[3]  = mk(1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0,    4, 0, 0, 1, 'h10,  'h0C00);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,    4, 0, 0, 1, 0,     'h0C00);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,    4, 4, 0, 1, 0,     'h0C00);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0,    4, 0, 0, 1, 0,     'h0C00);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0,    0, 0, 0, 0, 0,     'h0000);
    vecs[8]  = mk(1, 0, 4, 3, 0, 0, 0, 0, 1, 2, 0, 0,    1, 1, 0, 1, 0,     'h0004);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,    1, 0, 0, 1, 0,     'h0004);
    vecs[10] = mk(1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 1, 0,     'h0004);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0,     'h0000);
    vecs[12] = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,    1, 1, 0, 1, 0,     'h0005);
    vecs[13] = mk(1, 1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0,    3, 3, 2, 2, 0,     'h00C5);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0,    3, 1, 2, 2, 0,     'h00C5);
    vecs[15] = mk(1, 2, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0,    7, 1, 6, 3, 'h10,  'h20C5);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,    1, 1, 0, 1, 0,     'h0005);
    vecs[17] = mk(1, 2, 10, 0, 0, 1, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 0,     'h0005);
    vecs[18] = mk(1, 2, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0,   5, 5, 0, 2, 0,     'h2805);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0,    5, 0, 0, 2, 0,     'h2805);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0,    0, 0, 0, 0, 0,     'h0000);
    vecs[21] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0,    1, 1, 1, 1, 0,     'h0001);
    vecs[22] = mk(1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0,    3, 1, 3, 2, 'h04,  'h0041);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,    3, 1, 0, 2, 'h04,  'h0041);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,    3, 1, 0, 2, 'h04,  'h0041);
    vecs[25] = mk(1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,    7, 5, 0, 3, 'h04,  'h0C41);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0,    7, 0, 0, 3, 'h04,  'h0C41);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0,    2, 2, 0, 1, 0,     'h0040);
    vecs[28] = mk(1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,    3, 3, 1, 2, 0,     'h0045);
    vecs[29] = mk(1, 2, 9, 0, 0, 1, 0, 0, 0, 0, 1, 1,    2, 2, 0, 1, 0,     'h0040);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0,    2, 2, 0, 1, 0,     'h0040);

    idle_inputs();
    nRST = 0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1;
    #1;
    chk("reset.busy",        64'(busy),        64'h0);
    chk("reset.issue_ready", 64'(issue_ready), 64'h0);
    chk("reset.disp_ready",  64'(disp_ready),  64'h7);
    chk("reset.num_busy",    64'(num_busy),    64'h0);
    check_model("reset");

    for (int v = 0; v < 31; v++) begin
      idle_inputs();
      disp_en = vecs[v].de; disp_fu = vecs[v].fu; disp_rd = vecs[v].rd;
      disp_rs1 = vecs[v].rd + 5'd1; disp_rs2 = ~vecs[v].rd;
      disp_t1 = vecs[v].t1; disp_t2 = vecs[v].t2; disp_spec = vecs[v].sp;
      issue_en = vecs[v].iss; done_en = vecs[v].done; wb_en = vecs[v].we;
      wb_fu = vecs[v].wf; flush = vecs[v].fl; resolved = vecs[v].rs;
      step();
      $display("vec %0d: busy=%b ready=%b spec=%b num_busy=%0d", v, busy, issue_ready, ent_spec, num_busy);
      chk($sformatf("vec%0d.busy", v),     64'(busy),        64'(vecs[v].e_busy));
      chk($sformatf("vec%0d.ready", v),    64'(issue_ready), 64'(vecs[v].e_ir));
      chk($sformatf("vec%0d.spec", v),     64'(ent_spec),    64'(vecs[v].e_spec));
      chk($sformatf("vec%0d.num_busy", v), 64'(num_busy),    64'(vecs[v].e_nb));
      chk($sformatf("vec%0d.t1", v),       64'(ent_t1),      64'(vecs[v].e_t1));
      chk($sformatf("vec%0d.rd", v),       64'(ent_rd),      64'(vecs[v].e_rd));
      check_model($sformatf("vec%0d", v));
    end

    // Fill every entry, then drop reset between edges: outputs must clear before the next edge.
    idle_inputs();
    done_en = '1;
    step();
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      disp_en = 1; disp_fu = FW'(i); disp_rd = RW'(20 + i); disp_t1 = TW'(i); disp_spec = 1'(i);
      step();
      $display("fill entry %0d: busy=%b num_busy=%0d", i, busy, num_busy);
    end
    idle_inputs();
    check_model("fill");
    #2;
    nRST = 0;
    #1;
    m_reset();
    $display("async reset: busy=%b num_busy=%0d", busy, num_busy);
    chk("areset.busy",        64'(busy),        64'h0);
    chk("areset.num_busy",    64'(num_busy),    64'h0);
    chk("areset.disp_ready",  64'(disp_ready),  64'h7);
    chk("areset.issue_ready", 64'(issue_ready), 64'h0);
    chk("areset.rd",          64'(ent_rd),      64'h0);
    check_model("areset");
    @(negedge CLK);
    nRST = 1;
    #1;

    for (int c = 0; c < 1500; c++) begin
      disp_en   = 1'($urandom_range(0, 1));
      disp_fu   = FW'($urandom_range(0, N - 1));
      disp_rd   = RW'($urandom);
      disp_rs1  = RW'($urandom);
      disp_rs2  = RW'($urandom);
      disp_t1   = TW'($urandom_range(0, 3));
      disp_t2   = TW'($urandom_range(0, 3));
      disp_spec = 1'($urandom_range(0, 1));
      issue_en  = N'($urandom);
      done_en   = N'($urandom);
      wb_en     = 1'($urandom_range(0, 1));
      wb_fu     = FW'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 15) == 0);
      resolved  = ($urandom_range(0, 7) == 0);
      step();
      $display("rand %0d: de=%b fu=%0d wb=%b/%0d fl=%b rs=%b busy=%b ready=%b nb=%0d",
               c, disp_en, disp_fu, wb_en, wb_fu, flush, resolved, busy, issue_ready, num_busy);
      check_model($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
